// File: rtl/regfile_wb_sched_if.sv
// Bundle between the issue/execute/memory stages and the write-back scheduler.
// master = pipeline side, slave = scheduler side.
interface regfile_wb_sched_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32
);
  localparam int AW = $clog2(REG_NUM);
  localparam int CW = $clog2(REG_NUM) + 1;

  logic                  iss_valid;
  logic [AW-1:0]         iss_rd_addr;
  logic                  iss_ready;
  logic [AW-1:0]         chk_rs1_addr;
  logic                  chk_rs1_busy;
  logic [AW-1:0]         chk_rs2_addr;
  logic                  chk_rs2_busy;
  logic                  wb0_valid;
  logic [AW-1:0]         wb0_addr;
  logic [DATA_WIDTH-1:0] wb0_data;
  logic                  wb0_ready;
  logic                  wb1_valid;
  logic [AW-1:0]         wb1_addr;
  logic [DATA_WIDTH-1:0] wb1_data;
  logic                  wb1_ready;
  logic                  flush;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_wren;
  logic [CW-1:0]         busy_cnt;
  logic                  wb_err;

  modport master (
    output iss_valid, iss_rd_addr, chk_rs1_addr, chk_rs2_addr,
           wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data, flush,
    input  iss_ready, chk_rs1_busy, chk_rs2_busy, wb0_ready, wb1_ready,
           rd_addr, rd_data, rd_wren, busy_cnt, wb_err
  );

  modport slave (
    input  iss_valid, iss_rd_addr, chk_rs1_addr, chk_rs2_addr,
           wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data, flush,
    output iss_ready, chk_rs1_busy, chk_rs2_busy, wb0_ready, wb1_ready,
           rd_addr, rd_data, rd_wren, busy_cnt, wb_err
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Round-robin write-back arbiter for the register file's single write port,
// plus the per-register busy scoreboard used by issue for RAW/WAW detection.
module regfile_wb_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32
) (
  input  logic               clk,
  input  logic               rst,
  regfile_wb_sched_if.slave  bus
);
  localparam int AW = $clog2(REG_NUM);
  localparam int CW = $clog2(REG_NUM) + 1;

  typedef enum logic {
    GRANT_WB0 = 1'b0,
    GRANT_WB1 = 1'b1
  } grant_e;

  logic [REG_NUM-1:0]    r_busy;
  logic [CW-1:0]         r_busy_cnt;
  grant_e                r_last_grant;
  logic [AW-1:0]         r_rd_addr;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_wren;
  logic                  r_wb_err;

  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_hs;
  logic [AW-1:0]         w_wb_addr;
  logic [DATA_WIDTH-1:0] w_wb_data;
  logic                  w_iss_acc;
  logic                  w_wb_err_set;
  logic [REG_NUM-1:0]    w_busy_next;
  logic [CW-1:0]         w_cnt_next;

  // On a tie the requester that did not win last time is granted.
  assign w_grant0 = bus.wb0_valid & (~bus.wb1_valid | (r_last_grant == GRANT_WB1));
  assign w_grant1 = bus.wb1_valid & (~bus.wb0_valid | (r_last_grant == GRANT_WB0));
  assign w_hs     = w_grant0 | w_grant1;

  assign w_wb_addr = w_grant0 ? bus.wb0_addr : bus.wb1_addr;
  assign w_wb_data = w_grant0 ? bus.wb0_data : bus.wb1_data;

  assign w_iss_acc    = bus.iss_valid & ~r_busy[bus.iss_rd_addr] & ~bus.flush;
  assign w_wb_err_set = w_hs & (w_wb_addr != '0) & ~r_busy[w_wb_addr] & ~bus.flush;

  always_comb begin
    // NOTE: every variable gets a full default first so no path can infer a latch.
    w_busy_next = bus.flush ? '0 : r_busy;
    if (w_hs) begin
      w_busy_next[w_wb_addr] = 1'b0;
    end
    if (w_iss_acc) begin
      w_busy_next[bus.iss_rd_addr] = 1'b1;
    end
    w_busy_next[0] = 1'b0;

    w_cnt_next = '0;
    for (int i = 1; i < REG_NUM; i++) begin
      w_cnt_next = w_cnt_next + CW'(w_busy_next[i]);
    end
  end

  // NOTE: the busy vector is a flop array, not a RAM, so it is reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy       <= '0;
      r_busy_cnt   <= '0;
      r_last_grant <= GRANT_WB1;
      r_rd_addr    <= '0;
      r_rd_data    <= '0;
      r_rd_wren    <= 1'b0;
      r_wb_err     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      r_busy     <= w_busy_next;
      r_busy_cnt <= w_cnt_next;
      r_rd_wren  <= w_hs & (w_wb_addr != '0);
      if (w_hs) begin
        r_rd_addr    <= w_wb_addr;
        r_rd_data    <= w_wb_data;
        r_last_grant <= w_grant0 ? GRANT_WB0 : GRANT_WB1;
      end
      if (w_wb_err_set) begin
        r_wb_err <= 1'b1;
      end
    end
  end

  assign bus.iss_ready    = w_iss_acc;
  assign bus.wb0_ready    = w_grant0;
  assign bus.wb1_ready    = w_grant1;
  assign bus.chk_rs1_busy = r_busy[bus.chk_rs1_addr];
  assign bus.chk_rs2_busy = r_busy[bus.chk_rs2_addr];
  assign bus.rd_addr      = r_rd_addr;
  assign bus.rd_data      = r_rd_data;
  assign bus.rd_wren      = r_rd_wren;
  assign bus.busy_cnt     = r_busy_cnt;
  assign bus.wb_err       = r_wb_err;
endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
Write-back scheduler and scoreboard in front of the register file's single write port. It arbitrates two write-back requesters (ALU and load unit) onto rd_addr/rd_data/rd_wren using a round-robin policy. It also keeps a per-register busy scoreboard, set at issue and cleared at write-back, so the issue stage can detect RAW/WAW hazards. It sits between the execute/memory stages and the register file.

Parameters:
DATA_WIDTH, 32, register data width
REG_NUM, 32, number of registers; AW = clog2(REG_NUM), CW = clog2(REG_NUM)+1

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
iss_valid  in  1  issue stage requests to reserve destination register
iss_rd_addr  in  AW  destination register of issuing instruction
iss_ready  out  1  reservation accepted this cycle
chk_rs1_addr  in  AW  source 1 hazard query
chk_rs1_busy  out  1  source 1 has a pending write
chk_rs2_addr  in  AW  source 2 hazard query
chk_rs2_busy  out  1  source 2 has a pending write
wb0_valid  in  1  ALU write-back request
wb0_addr  in  AW  ALU write-back register
wb0_data  in  DATA_WIDTH  ALU write-back data
wb0_ready  out  1  ALU request granted
wb1_valid  in  1  load-unit write-back request
wb1_addr  in  AW  load-unit write-back register
wb1_data  in  DATA_WIDTH  load-unit write-back data
wb1_ready  out  1  load-unit request granted
flush  in  1  pipeline flush; clears all reservations
rd_addr  out  AW  register file write address (registered)
rd_data  out  DATA_WIDTH  register file write data (registered)
rd_wren  out  1  register file write enable (registered)
busy_cnt  out  CW  number of busy registers
wb_err  out  1  sticky: write-back to a register that is not busy

Behaviour:
- Reset (async, rst=1): busy[] all 0; rd_addr=0, rd_data=0, rd_wren=0; wb_err=0; last_grant=1, so wb0 wins the first tie. Reset mid-transfer discards the registered write: rd_wren drops immediately.
- Arbitration is combinational within the cycle:
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester other than last_grant gets ready=1; last_grant updates on every handshake.
  - Never more than one ready high per cycle. ready never depends on rd_wren, so there is no backpressure from the register file.
- Write port: on the edge where wbX_valid & wbX_ready, rd_addr/rd_data take wbX_addr/data on the next cycle (1-cycle latency).
  - rd_wren=1 for that cycle only if addr≠0; addr 0 is handshaked but rd_wren=0.
  - With no handshake, rd_wren=0 and rd_addr/rd_data hold their values.
- Scoreboard:
  - busy[0] is constant 0.
  - At the edge of an accepted write-back to addr A, busy[A] is cleared. The clear is visible the cycle rd_wren is high.
  - An accepted write-back to a non-busy A≠0 sets wb_err=1 (sticky until reset); the write is still performed.
- Issue: iss_ready = iss_valid & ~busy[iss_rd_addr] & ~flush.
  - On accept with iss_rd_addr≠0, busy[iss_rd_addr] is set at the edge.
  - iss_rd_addr=0 is always accepted when not flushing and reserves nothing.
- Same-edge issue and write-back to the same A: not possible, because iss_ready requires busy[A]=0 and a write-back requires a prior reservation. If an erroneous write-back occurs, the set wins and wb_err is raised.
- Hazard outputs: chk_rsN_busy = busy[chk_rsN_addr], combinational from current state. There is no same-cycle bypass of a write-back granted this cycle; the consumer sees busy clear the next cycle.
- flush: at the edge, all busy bits are cleared and any issue that cycle is rejected. A write-back in the same cycle is still arbitrated and written; it does not raise wb_err in that cycle or afterwards for that flush.
- busy_cnt equals popcount(busy), updated registered alongside busy. The maximum is REG_NUM-1.

Test Plan:
- Reset, then iss rd=5 → iss_ready=1. Next cycle chk_rs1_addr=5 → busy=1, busy_cnt=1. iss rd=5 again → iss_ready=0 (WAW stall).
- Reserve r5, then wb0 addr=5 data=0xDEADBEEF → wb0_ready=1. Next cycle rd_wren=1, rd_addr=5, rd_data=0xDEADBEEF, chk_rs1_busy(5)=0, busy_cnt=0.
- Reserve r3/r4, both wb valid for 4 cycles → grants alternate wb0, wb1, wb0, wb1. rd_wren is high for 4 consecutive cycles; never two readies in one cycle.
- Issue rd=0 and wb1 addr=0 → iss_ready=1, busy_cnt stays 0, wb1_ready=1, rd_wren stays 0, wb_err=0.
- wb0 addr=7 with r7 not reserved → write performed, wb_err=1 and remains 1 after later good write-backs.
- Reserve r1, r2, r9; assert flush with simultaneous iss rd=10 and wb0 addr=2 → iss_ready=0. Next cycle busy_cnt=0 and rd_wren=1 for r2. Assert rst mid-sequence → all outputs 0 asynchronously.
